// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with a bounded memory wait.
// Define ILLEGAL_TRAP_EN to add the illegal_instr output and a sticky TRAP state.
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W   = 6,
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [5:0]              opcode,
    input  logic [5:0]              func,
    input  logic                    alu_zero,
    input  logic                    mem_ready,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_jump_enable,
    output logic                    pc_conditional_branch,
    output logic [1:0]              alu_operand_source,
    output logic [ALU_CTRL_W-1:0]   alu_control,
    output logic                    dm_read_enable,
    output logic                    dm_write_enable,
    output logic                    rm_write_data_source,
    output logic                    rm_write_enable,
    output logic                    mem_timeout,
    output logic [RETIRE_CNT_W-1:0] retired_count,
`ifdef ILLEGAL_TRAP_EN
    output logic                    illegal_instr,
`endif
    output logic                    busy
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpLw    = 6'h23;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnXor = 6'h26;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnNop = 6'h00;

    // Local copy of the shared ALU operation encodings.
    localparam logic [ALU_CTRL_W-1:0] AluNoop = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] AluAdd  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] AluSub  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] AluAnd  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] AluXor  = ALU_CTRL_W'(4);

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
`ifdef ILLEGAL_TRAP_EN
        StTrap   = 3'd5,
`endif
        StWb     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        InsNop, InsIllegal, InsAdd, InsAnd, InsSub, InsXor,
        InsAddi, InsAndi, InsJr, InsBeq, InsLw, InsSw
    } ins_e;

    state_e state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] func_q, func_d;
    logic [7:0] wait_q, wait_d;
    logic [RETIRE_CNT_W-1:0] retired_count_q;
    logic retire;
    ins_e ins;

    assign retired_count = retired_count_q;

    // Classify the latched instruction once; the FSM only looks at the class.
    always_comb begin
        ins = InsIllegal;
        unique case (opcode_q)
            OpRtype: begin
                unique case (func_q)
                    FnAdd:   ins = InsAdd;
                    FnAnd:   ins = InsAnd;
                    FnSub:   ins = InsSub;
                    FnXor:   ins = InsXor;
                    FnJr:    ins = InsJr;
                    FnNop:   ins = InsNop;
                    default: ins = InsIllegal;
                endcase
            end
            OpAddi:  ins = InsAddi;
            OpAndi:  ins = InsAndi;
            OpBeq:   ins = InsBeq;
            OpSw:    ins = InsSw;
            OpLw:    ins = InsLw;
            default: ins = InsIllegal;
        endcase
    end

    always_comb begin
        state_d               = state_q;
        opcode_d              = opcode_q;
        func_d                = func_q;
        wait_d                = wait_q;
        retire                = 1'b0;
        instr_ready           = 1'b0;
        ir_write              = 1'b0;
        pc_write              = 1'b0;
        pc_jump_enable        = 1'b0;
        pc_conditional_branch = 1'b0;
        alu_operand_source    = 2'd0;
        alu_control           = AluNoop;
        dm_read_enable        = 1'b0;
        dm_write_enable       = 1'b0;
        rm_write_data_source  = 1'b0;
        rm_write_enable       = 1'b0;
        mem_timeout           = 1'b0;
        busy                  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr         = 1'b0;
`endif
        unique case (state_q)
            StFetch: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_write = 1'b1;
                    opcode_d = opcode;
                    func_d   = func;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                busy    = 1'b1;
                state_d = StExec;
`ifdef ILLEGAL_TRAP_EN
                if (ins == InsIllegal) begin
                    illegal_instr = 1'b1;
                    state_d       = StTrap;
                end
`endif
            end
            StExec: begin
                busy = 1'b1;
                unique case (ins)
                    InsAdd: begin
                        alu_control = AluAdd;
                        state_d     = StWb;
                    end
                    InsAnd: begin
                        alu_control = AluAnd;
                        state_d     = StWb;
                    end
                    InsSub: begin
                        alu_control = AluSub;
                        state_d     = StWb;
                    end
                    InsXor: begin
                        alu_control = AluXor;
                        state_d     = StWb;
                    end
                    InsAddi: begin
                        alu_control        = AluAdd;
                        alu_operand_source = 2'd1;
                        state_d            = StWb;
                    end
                    InsAndi: begin
                        alu_control        = AluAnd;
                        alu_operand_source = 2'd1;
                        state_d            = StWb;
                    end
                    InsJr: begin
                        pc_write       = 1'b1;
                        pc_jump_enable = 1'b1;
                        retire         = 1'b1;
                        state_d        = StFetch;
                    end
                    InsBeq: begin
                        alu_operand_source    = 2'd1;
                        pc_jump_enable        = 1'b1;
                        pc_conditional_branch = 1'b1;
                        pc_write              = alu_zero;
                        retire                = 1'b1;
                        state_d               = StFetch;
                    end
                    InsLw, InsSw: begin
                        alu_control        = AluAdd;
                        alu_operand_source = 2'd1;
                        state_d            = StMem;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMem: begin
                busy            = 1'b1;
                dm_read_enable  = (ins == InsLw);
                dm_write_enable = (ins == InsSw);
                // A late mem_ready still beats the timeout on the same cycle.
                if (mem_ready) begin
                    wait_d = '0;
                    if (ins == InsLw) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else if (wait_q == WaitLast) begin
                    mem_timeout = 1'b1;
                    wait_d      = '0;
                    state_d     = StFetch;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWb: begin
                busy                 = 1'b1;
                rm_write_enable      = 1'b1;
                rm_write_data_source = (ins == InsLw);
                retire               = 1'b1;
                state_d              = StFetch;
            end
`ifdef ILLEGAL_TRAP_EN
            StTrap: begin
                busy = 1'b1;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StFetch;
            opcode_q        <= '0;
            func_q          <= '0;
            wait_q          <= '0;
            retired_count_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            func_q   <= func_d;
            wait_q   <= wait_d;
            if (retire) begin
                retired_count_q <= retired_count_q + RETIRE_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of per-instruction expectations, random
// instructions against a trace-level reference model, and reset/trap corner cases.
module tb_multicycle_control_unit;

    localparam int TMO = 15;
    localparam int A_NOOP = 0;
    localparam int A_ADD  = 1;
    localparam int A_SUB  = 2;
    localparam int A_AND  = 3;
    localparam int A_XOR  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [5:0]  opcode, func;
    logic        alu_zero, mem_ready;
    logic        ir_write, pc_write, pc_jump_enable, pc_conditional_branch;
    logic [1:0]  alu_operand_source;
    logic [5:0]  alu_control;
    logic        dm_read_enable, dm_write_enable;
    logic        rm_write_data_source, rm_write_enable, mem_timeout, busy;
    logic [31:0] retired_count;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    multicycle_control_unit #(
        .ALU_CTRL_W  (6),
        .MEM_TIMEOUT (TMO),
        .RETIRE_CNT_W(32)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .opcode               (opcode),
        .func                 (func),
        .alu_zero             (alu_zero),
        .mem_ready            (mem_ready),
        .ir_write             (ir_write),
        .pc_write             (pc_write),
        .pc_jump_enable       (pc_jump_enable),
        .pc_conditional_branch(pc_conditional_branch),
        .alu_operand_source   (alu_operand_source),
        .alu_control          (alu_control),
        .dm_read_enable       (dm_read_enable),
        .dm_write_enable      (dm_write_enable),
        .rm_write_data_source (rm_write_data_source),
        .rm_write_enable      (rm_write_enable),
        .mem_timeout          (mem_timeout),
        .retired_count        (retired_count),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr        (illegal_instr),
`endif
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       irw;
        logic       pcw;
        logic       jmp;
        logic       cond;
        logic [1:0] src;
        logic [5:0] alu;
        logic       dmr;
        logic       dmw;
        logic       wsrc;
        logic       rwe;
        logic       tmo;
        logic       busy;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {instr_ready, ir_write, pc_write, pc_jump_enable, pc_conditional_branch,
                    alu_operand_source, alu_control, dm_read_enable, dm_write_enable,
                    rm_write_data_source, rm_write_enable, mem_timeout, busy};

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int         delay;   // MEM cycle index where mem_ready rises, -1 = never
        int         cycles;  // accept to next instr_ready
        int         retire;
        int         dmr, dmw, rwe, wsrc, pcw, cond, tmo;
        int         alu, src;  // sampled in EXEC
    } row_t;

    row_t        rows[$];
    outs_t       exp_q[$];
    bit          rdy_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_retired = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic outs_t idle_outs();
        outs_t o;
        o = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    // Reference: the cycle-by-cycle output trace one instruction should produce from accept.
    task automatic build_trace(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                               input int delay, output int ret);
        outs_t o;
        int    alu = A_NOOP;
        int    src = 0;
        bit    wb = 0, mem = 0, lw = 0, jr = 0, beq = 0, ready;
        exp_q.delete();
        rdy_q.delete();
        case (op)
            6'h00: case (fn)
                6'h20: begin alu = A_ADD; wb = 1; end
                6'h24: begin alu = A_AND; wb = 1; end
                6'h22: begin alu = A_SUB; wb = 1; end
                6'h26: begin alu = A_XOR; wb = 1; end
                6'h08: jr = 1;
                default: ;
            endcase
            6'h08: begin alu = A_ADD; src = 1; wb = 1; end
            6'h0C: begin alu = A_AND; src = 1; wb = 1; end
            6'h04: begin src = 1; beq = 1; end
            6'h23: begin alu = A_ADD; src = 1; mem = 1; lw = 1; end
            6'h2B: begin alu = A_ADD; src = 1; mem = 1; end
            default: ;
        endcase
        ret = 1;
        o = idle_outs();
        o.irw = 1'b1;
        exp_q.push_back(o); rdy_q.push_back(1'b0);
        o = '0; o.busy = 1'b1;
        exp_q.push_back(o); rdy_q.push_back(1'b0);
        o.alu = 6'(alu); o.src = 2'(src);
        o.pcw = jr || (beq && zero); o.jmp = jr || beq; o.cond = beq;
        exp_q.push_back(o); rdy_q.push_back(1'b0);
        if (mem) begin
            for (int k = 0; k < TMO; k++) begin
                ready = (k == delay);
                o = '0; o.busy = 1'b1; o.dmr = lw; o.dmw = !lw;
                o.tmo = !ready && (k == TMO - 1);
                exp_q.push_back(o); rdy_q.push_back(ready);
                if (ready) break;
            end
            if (exp_q[exp_q.size() - 1].tmo) ret = 0;
            wb = lw && ret == 1;
        end
        if (wb) begin
            o = '0; o.busy = 1'b1; o.rwe = 1'b1; o.wsrc = lw;
            exp_q.push_back(o); rdy_q.push_back(1'b0);
        end
    endtask

    task automatic run_trace(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int delay);
        int ret;
        build_trace(op, fn, zero, delay, ret);
        for (int c = 0; c < exp_q.size(); c++) begin
            instr_valid = (c == 0);
            opcode      = (c == 0) ? op : 6'($urandom);
            func        = (c == 0) ? fn : 6'($urandom);
            alu_zero    = zero;
            mem_ready   = rdy_q[c];
            @(negedge clk);
            check($sformatf("%s op%0h fn%0h c%0d", name, op, fn, c), 32'(dut_o), 32'(exp_q[c]));
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        exp_retired += 32'(ret);
        @(negedge clk);
        check({name, " retired"}, retired_count, exp_retired);
        check({name, " idle"}, 32'(dut_o), 32'(idle_outs()));
        @(posedge clk); #1;
    endtask

    task automatic run_row(input int idx, input row_t r);
        int    cyc = 0, memk = 0;
        int    ndmr = 0, ndmw = 0, nrwe = 0, nwsrc = 0, npcw = 0, ncond = 0, ntmo = 0;
        int    alu = -1, src = -1;
        bit    done = 0;
        string nm = $sformatf("row%0d", idx);
        while (!done && cyc < 100) begin
            instr_valid = (cyc == 0);
            opcode      = (cyc == 0) ? r.op : 6'($urandom);
            func        = (cyc == 0) ? r.fn : 6'($urandom);
            alu_zero    = r.zero;
            if (dm_read_enable || dm_write_enable) begin
                mem_ready = (memk == r.delay);
                memk++;
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            if (cyc > 0 && instr_ready) begin
                done = 1;
            end else begin
                ndmr  += int'(dm_read_enable);
                ndmw  += int'(dm_write_enable);
                nrwe  += int'(rm_write_enable);
                nwsrc += int'(rm_write_data_source);
                npcw  += int'(pc_write);
                ncond += int'(pc_conditional_branch);
                ntmo  += int'(mem_timeout);
                if (cyc == 2) begin
                    alu = int'(alu_control);
                    src = int'(alu_operand_source);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({nm, " finished"}, 32'(done), 32'd1);
        check({nm, " cycles"}, cyc, r.cycles);
        exp_retired += 32'(r.retire);
        check({nm, " retired"}, retired_count, exp_retired);
        check({nm, " dm_read"}, ndmr, r.dmr);
        check({nm, " dm_write"}, ndmw, r.dmw);
        check({nm, " rm_write"}, nrwe, r.rwe);
        check({nm, " wdata_src"}, nwsrc, r.wsrc);
        check({nm, " pc_write"}, npcw, r.pcw);
        check({nm, " cond"}, ncond, r.cond);
        check({nm, " timeout"}, ntmo, r.tmo);
        check({nm, " exec_alu"}, alu, r.alu);
        check({nm, " exec_src"}, src, r.src);
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        if (done) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [6] = '{6'h00, 6'h08, 6'h0C, 6'h04, 6'h2B, 6'h23};
        int i = int'($urandom_range(0, 6));
`ifndef ILLEGAL_TRAP_EN
        if (i == 6) return 6'($urandom);
`endif
        return ops[i % 6];
    endfunction

    function automatic logic [5:0] rand_fn();
        logic [5:0] fns [6] = '{6'h20, 6'h24, 6'h22, 6'h26, 6'h08, 6'h00};
        int i = int'($urandom_range(0, 6));
`ifndef ILLEGAL_TRAP_EN
        if (i == 6) return 6'($urandom);
`endif
        return fns[i % 6];
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        //            op     fn     z  dly cyc ret dmr dmw rwe wsrc pcw cond tmo alu     src
        rows.push_back('{6'h00, 6'h20, 0, -1, 4, 1, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0});
        rows.push_back('{6'h00, 6'h22, 0, -1, 4, 1, 0, 0, 1, 0, 0, 0, 0, A_SUB, 0});
        rows.push_back('{6'h00, 6'h24, 0, -1, 4, 1, 0, 0, 1, 0, 0, 0, 0, A_AND, 0});
        rows.push_back('{6'h00, 6'h26, 0, -1, 4, 1, 0, 0, 1, 0, 0, 0, 0, A_XOR, 0});
        rows.push_back('{6'h08, 6'h3F, 0, -1, 4, 1, 0, 0, 1, 0, 0, 0, 0, A_ADD, 1});
        rows.push_back('{6'h0C, 6'h11, 0, -1, 4, 1, 0, 0, 1, 0, 0, 0, 0, A_AND, 1});
        rows.push_back('{6'h04, 6'h00, 1, -1, 3, 1, 0, 0, 0, 0, 1, 1, 0, A_NOOP, 1});
        rows.push_back('{6'h04, 6'h00, 0, -1, 3, 1, 0, 0, 0, 0, 0, 1, 0, A_NOOP, 1});
        rows.push_back('{6'h00, 6'h08, 0, -1, 3, 1, 0, 0, 0, 0, 1, 0, 0, A_NOOP, 0});
        rows.push_back('{6'h00, 6'h00, 1, -1, 3, 1, 0, 0, 0, 0, 0, 0, 0, A_NOOP, 0});
        rows.push_back('{6'h23, 6'h00, 0, 3, 8, 1, 4, 0, 1, 1, 0, 0, 0, A_ADD, 1});
        rows.push_back('{6'h2B, 6'h00, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 1});
        rows.push_back('{6'h2B, 6'h00, 0, -1, 18, 0, 0, 15, 0, 0, 0, 0, 1, A_ADD, 1});
        rows.push_back('{6'h2B, 6'h00, 0, 14, 18, 1, 0, 15, 0, 0, 0, 0, 0, A_ADD, 1});
        rows.push_back('{6'h23, 6'h00, 0, -1, 18, 0, 15, 0, 0, 0, 0, 0, 1, A_ADD, 1});
`ifndef ILLEGAL_TRAP_EN
        rows.push_back('{6'h3F, 6'h20, 0, -1, 3, 1, 0, 0, 0, 0, 0, 0, 0, A_NOOP, 0});
        rows.push_back('{6'h00, 6'h3F, 0, -1, 3, 1, 0, 0, 0, 0, 0, 0, 0, A_NOOP, 0});
`endif

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 6'h00;
        func        = 6'h00;
        alu_zero    = 1'b0;
        mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 32'(dut_o), 32'(idle_outs()));
        check("reset retired", retired_count, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset outputs", 32'(dut_o), 32'(idle_outs()));

        foreach (rows[i]) run_row(i, rows[i]);

        for (int n = 0; n < 60; n++) begin
            run_trace("rand", rand_op(), rand_fn(), 1'($urandom), int'($urandom_range(0, 16)));
        end

        // Asynchronous reset in the middle of a stalled load.
        instr_valid = 1'b1;
        opcode      = 6'h23;
        func        = 6'h00;
        mem_ready   = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid-mem dm_read", 32'(dm_read_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async dm_read drop", 32'(dm_read_enable), 32'd0);
        check("async outputs", 32'(dut_o), 32'(idle_outs()));
        check("async retired", retired_count, 32'd0);
        #3 rst_n = 1'b1;
        exp_retired = 0;
        @(posedge clk); #1;
        check("after async reset", 32'(dut_o), 32'(idle_outs()));
        run_trace("post-reset add", 6'h00, 6'h20, 1'b0, -1);

`ifdef ILLEGAL_TRAP_EN
        instr_valid = 1'b1;
        opcode      = 6'h3F;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("trap pulse", 32'(illegal_instr), 32'd1);
        check("trap decode busy", 32'(busy), 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            instr_valid = 1'(c % 2);
            check($sformatf("trap hold c%0d", c), {illegal_instr, 12'h0, 1'b0, dut_o}, 32'd1);
        end
        check("trap retired", retired_count, exp_retired);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        instr_valid = 1'b0;
        exp_retired = 0;
        @(posedge clk); #1;
        check("trap reset", 32'(dut_o), 32'(idle_outs()));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
